// File: rtl/alu_result_stage_if.sv
// Handshake bundle between the ALU result stage, its upstream ALU and its downstream consumer.
// The master side is the environment (ALU + consumer); the slave side is the stage itself.
interface alu_result_stage_if;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_op;
   logic [3:0] in_result;
   logic       in_carry;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] out_op;
   logic [3:0] out_result;
   logic       out_carry;
   logic       out_zero;
   logic       out_neg;

   modport master (
      output in_valid, in_op, in_result, in_carry, out_ready,
      input  in_ready, out_valid, out_op, out_result, out_carry, out_zero, out_neg
   );

   modport slave (
      input  in_valid, in_op, in_result, in_carry, out_ready,
      output in_ready, out_valid, out_op, out_result, out_carry, out_zero, out_neg
   );
endinterface

// File: rtl/alu_result_stage.sv
// Result stage behind the 4-bit ALU: tags each result with zero/negative flags, buffers it
// in a small FIFO and hands it to the consumer over valid/ready, counting completed results.
module alu_result_stage #(
   parameter int DEPTH = 2,
   parameter int CW    = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   alu_result_stage_if.slave    bus,
   output logic [CW-1:0]        done_count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   typedef struct packed {
      logic [3:0] op;
      logic [3:0] result;
      logic       carry;
      logic       zero;
      logic       neg;
   } entry_t;

   entry_t        mem [DEPTH];
   entry_t        in_entry;
   entry_t        head;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] last_ptr;
   logic [AW:0]   count;
   logic          push;
   logic          pop;

   assign bus.in_ready  = (count != FULL);
   assign bus.out_valid = (count != '0);
   assign push          = bus.in_valid && bus.in_ready;
   assign pop           = bus.out_valid && bus.out_ready;

   assign in_entry = {bus.in_op, bus.in_result, bus.in_carry,
                      (bus.in_result == 4'b0000), bus.in_result[3]};

   // When empty, show the slot just vacated; it is not rewritten until the FIFO refills past it.
   assign last_ptr = rd_ptr - 1'b1;
   assign head     = (count != '0) ? mem[rd_ptr] : mem[last_ptr];

   assign bus.out_op     = head.op;
   assign bus.out_result = head.result;
   assign bus.out_carry  = head.carry;
   assign bus.out_zero   = head.zero;
   assign bus.out_neg    = head.neg;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         done_count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (push) begin
            mem[wr_ptr] <= in_entry;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr     <= rd_ptr + 1'b1;
            done_count <= done_count + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage: directed vectors push expectations into a queue,
// an independent negedge monitor checks handshake state and pops/compares delivered entries.
module tb_alu_result_stage;

   localparam int DEPTH = 2;
   localparam int CW    = 8;

   typedef struct packed {
      logic [3:0] op;
      logic [3:0] res;
      logic       c;
      logic       z;
      logic       n;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic [CW-1:0] done_count;

   alu_result_stage_if bus ();

   alu_result_stage #(.DEPTH(DEPTH), .CW(CW)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus.slave),
      .done_count (done_count)
   );

   always #5 clk = ~clk;

   int            checks = 0;
   int            passes = 0;
   exp_t          expQ[$];
   int            modelCount = 0;
   logic [CW-1:0] modelDone = '0;
   bit            monitorOn = 1'b0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // Drive one cycle of inputs; returns #1 after the edge that consumed them.
   task automatic applyStimulus(input logic v, input logic [3:0] op, input logic [3:0] res,
                                input logic c, input logic rdy);
      bus.in_valid  = v;
      bus.in_op     = op;
      bus.in_result = res;
      bus.in_carry  = c;
      bus.out_ready = rdy;
      @(posedge clk);
      #1;
   endtask

   // Reference occupancy/pop-count model; accepted pushes become scoreboard expectations.
   always @(posedge clk) begin
      if (rst) begin
         modelCount <= 0;
         modelDone  <= '0;
         expQ.delete();
      end else begin
         automatic bit doPush = bus.in_valid && (modelCount != DEPTH);
         automatic bit doPop  = bus.out_ready && (modelCount != 0);
         if (doPush)
            expQ.push_back('{op: bus.in_op, res: bus.in_result, c: bus.in_carry,
                             z: (bus.in_result == 4'd0), n: bus.in_result[3]});
         if (doPop) modelDone <= modelDone + 1'b1;
         modelCount <= modelCount + int'(doPush) - int'(doPop);
      end
   end

   always @(negedge clk) begin
      if (monitorOn && !rst) begin
         checkOutput("out_valid", 32'(bus.out_valid), 32'(modelCount != 0));
         checkOutput("in_ready", 32'(bus.in_ready), 32'(modelCount != DEPTH));
         checkOutput("done_count", 32'(done_count), 32'(modelDone));
         if (modelCount != 0) begin
            if (expQ.size() == 0) begin
               checkOutput("scoreboard_empty", 32'(expQ.size()), 32'd1);
            end else begin
               checkOutput("head_op", 32'(bus.out_op), 32'(expQ[0].op));
               checkOutput("head_result", 32'(bus.out_result), 32'(expQ[0].res));
               checkOutput("head_carry", 32'(bus.out_carry), 32'(expQ[0].c));
               checkOutput("head_zero", 32'(bus.out_zero), 32'(expQ[0].z));
               checkOutput("head_neg", 32'(bus.out_neg), 32'(expQ[0].n));
               if (bus.out_ready) void'(expQ.pop_front());
            end
         end
      end
   end

   initial begin
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_op     = 4'h0;
      bus.in_result = 4'h0;
      bus.in_carry  = 1'b0;
      bus.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      monitorOn = 1'b1;

      checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
      checkOutput("rst_done_count", 32'(done_count), 32'd0);
      checkOutput("rst_out_op", 32'(bus.out_op), 32'd0);
      checkOutput("rst_out_result", 32'(bus.out_result), 32'd0);
      checkOutput("rst_out_flags", 32'({bus.out_carry, bus.out_zero, bus.out_neg}), 32'd0);

      // Single push of 1010 then pop
      applyStimulus(1'b1, 4'h2, 4'b1010, 1'b0, 1'b0);
      checkOutput("t1_valid", 32'(bus.out_valid), 32'd1);
      checkOutput("t1_op", 32'(bus.out_op), 32'h2);
      checkOutput("t1_result", 32'(bus.out_result), 32'b1010);
      checkOutput("t1_neg", 32'(bus.out_neg), 32'd1);
      checkOutput("t1_zero", 32'(bus.out_zero), 32'd0);
      applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
      checkOutput("t1_done", 32'(done_count), 32'd1);
      checkOutput("t1_empty", 32'(bus.out_valid), 32'd0);

      // Zero result with carry (1000 + 1000)
      applyStimulus(1'b1, 4'h9, 4'b0000, 1'b1, 1'b0);
      checkOutput("t2_zero", 32'(bus.out_zero), 32'd1);
      checkOutput("t2_neg", 32'(bus.out_neg), 32'd0);
      checkOutput("t2_carry", 32'(bus.out_carry), 32'd1);
      applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
      checkOutput("t2_done", 32'(done_count), 32'd2);

      // Fill to full; third push refused
      applyStimulus(1'b1, 4'h1, 4'h1, 1'b0, 1'b0);
      applyStimulus(1'b1, 4'h2, 4'h2, 1'b0, 1'b0);
      checkOutput("t3_full", 32'(bus.in_ready), 32'd0);
      applyStimulus(1'b1, 4'h3, 4'h3, 1'b0, 1'b0);
      checkOutput("t3_still_full", 32'(bus.in_ready), 32'd0);
      checkOutput("t3_head1", 32'(bus.out_result), 32'h1);
      applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
      checkOutput("t3_head2", 32'(bus.out_result), 32'h2);
      checkOutput("t3_ready_back", 32'(bus.in_ready), 32'd1);
      applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
      checkOutput("t3_drained", 32'(bus.out_valid), 32'd0);
      checkOutput("t3_done", 32'(done_count), 32'd4);

      // Full with simultaneous pop and push attempt
      applyStimulus(1'b1, 4'h4, 4'h5, 1'b0, 1'b0);
      applyStimulus(1'b1, 4'h5, 4'h6, 1'b0, 1'b0);
      applyStimulus(1'b1, 4'h6, 4'h7, 1'b1, 1'b1);
      checkOutput("t4_ready_back", 32'(bus.in_ready), 32'd1);
      checkOutput("t4_head", 32'(bus.out_result), 32'h6);
      applyStimulus(1'b1, 4'h7, 4'h8, 1'b0, 1'b0);
      checkOutput("t4_full_again", 32'(bus.in_ready), 32'd0);
      checkOutput("t4_head_kept", 32'(bus.out_result), 32'h6);
      applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
      checkOutput("t4_next", 32'({bus.out_op, bus.out_result}), 32'h78);
      applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
      checkOutput("t4_done", 32'(done_count), 32'd7);

      // Reset with two entries buffered
      applyStimulus(1'b1, 4'hC, 4'h9, 1'b0, 1'b0);
      applyStimulus(1'b1, 4'hD, 4'hA, 1'b0, 1'b0);
      rst = 1'b1;
      applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
      rst = 1'b0;
      checkOutput("t6_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("t6_ready", 32'(bus.in_ready), 32'd1);
      checkOutput("t6_done", 32'(done_count), 32'd0);
      applyStimulus(1'b1, 4'hB, 4'h3, 1'b0, 1'b0);
      checkOutput("t6_push", 32'({bus.out_valid, bus.out_op, bus.out_result}), 32'h1B3);
      applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
      checkOutput("t6_done_after", 32'(done_count), 32'd1);

      // Streaming 300 results from a clean reset
      rst = 1'b1;
      applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
      rst = 1'b0;
      for (int i = 0; i < 300; i++) begin
         automatic logic [31:0] r = 32'(i) * 32'd7;
         applyStimulus(1'b1, 4'(i), r[3:0], 1'(i), 1'b1);
         checkOutput("t5_in_ready", 32'(bus.in_ready), 32'd1);
      end
      applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
      checkOutput("t5_done", 32'(done_count), 32'd44);
      checkOutput("t5_empty", 32'(bus.out_valid), 32'd0);
      checkOutput("t5_queue", 32'(expQ.size()), 32'd0);

      @(negedge clk);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
